ro_freq_counter: RTL and testbench
==================================

Name: ro_freq_counter

Overview:
- Measurement stage directly downstream of the ring oscillators in the VT sensor.
- Drives the RO enable and select inputs and opens a gate window of a programmed number of reference-clock cycles.
- Counts RO output rising edges during that window, then stops the RO and hands the settled count to the reference-clock domain with a valid pulse.
- Count value is proportional to RO frequency, which encodes voltage and temperature.

Parameters:
- CNT_W, 16, width of the edge counter and of o_Count.
- WIN_W, 16, width of the i_Window gate-length input.
- SETTLE_CYC, 4, reference cycles the block waits after disabling the RO before it captures the count (must be >= 2).

Ports:
- i_Clk  input  1  reference clock.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_Start  input  1  single-cycle request to start a measurement; sampled only in IDLE.
- i_Window  input  WIN_W  gate length in i_Clk cycles; latched on an accepted i_Start.
- i_RO_out  input  1  RO output (o_RO_out of the RO instance); asynchronous to i_Clk.
- o_RO_Enable  output  1  drives RO i_Enable.
- o_RO_Sel  output  1  drives RO i_Sel.
- o_Count  output  CNT_W  last captured edge count.
- o_Valid  output  1  one-cycle pulse when o_Count updates.
- o_Busy  output  1  high from the accepted start until capture.
- o_Overflow  output  1  the last measurement saturated.

Behaviour:
- Reset:
  - All outputs go to 0 asynchronously.
  - The FSM goes to IDLE.
  - The RO-domain counter clears asynchronously.
  - Reset mid-measurement stops the RO immediately and discards the measurement; no o_Valid is issued.
- Registers: o_RO_Enable and o_RO_Sel come straight from flops (glitch-free); there is no combinational path to the RO.
- FSM state IDLE:
  - o_Busy = 0.
  - An i_Start accepted while in IDLE latches i_Window, sets o_Busy = 1 and moves to CLEAR.
- FSM state CLEAR: for 1 cycle, assert the registered clear that asynchronously zeroes the RO-domain counter and overflow bit, then move to COUNT.
- FSM state COUNT:
  - o_RO_Enable = o_RO_Sel = 1 for exactly the latched window, in i_Clk cycles, then move to SETTLE.
  - A latched window of 0 skips COUNT: the RO is never enabled.
- FSM state SETTLE:
  - Enable and Sel are 0, so the RO output rests high.
  - Wait SETTLE_CYC cycles so the last RO edges propagate and the counter is static.
- FSM state CAPTURE, 1 cycle:
  - Sample the now-static counter and overflow bit directly into o_Count and o_Overflow; no synchronizer is needed because the value is static.
  - Pulse o_Valid.
  - Drop o_Busy in the next cycle and return to IDLE.
- Latency: from the i_Start edge to o_Valid is 1 (CLEAR) + W + SETTLE_CYC + 1 cycles.
- RO-domain counter:
  - Clocked on the rising edge of i_RO_out; counts only while the synchronised enable level is high.
  - Saturates at 2^CNT_W-1 and sets a sticky overflow bit there; it never wraps.
- o_Count and o_Overflow hold their values until the next CAPTURE.
- i_Start while busy is ignored; it is not queued.
- i_Start and CAPTURE in the same cycle: the start is ignored, because the FSM is not yet in IDLE.
- i_Window changes while busy have no effect.

Test Plan:
- Nominal:
  - Stimulus: i_Clk 10 ns; RO model with 27.94 ns period (127 stages x 110 ps x 2); i_Window = 100; pulse i_Start.
  - Required: o_RO_Enable high for exactly 100 cycles; o_Valid 106 cycles after start with SETTLE_CYC = 4; o_Count = 35 or 36; o_Overflow = 0.
- Zero window:
  - Stimulus: i_Window = 0, then i_Start.
  - Required: o_RO_Enable never rises; o_Valid after 6 cycles; o_Count = 0.
- Saturation:
  - Stimulus: CNT_W = 4, RO period 5 ns, i_Window = 20.
  - Required: o_Count = 15 and o_Overflow = 1. A following run with i_Window = 2 must clear o_Overflow to 0.
- Start while busy:
  - Stimulus: second i_Start 10 cycles into a 100-cycle window.
  - Required: a single o_Valid; timing and count identical to the nominal case.
- Reset mid-COUNT:
  - Stimulus: assert i_Rst_n low at cycle 50 of the window.
  - Required: o_RO_Enable, o_Busy and o_Count are 0 immediately, with no clock edge; no o_Valid follows; the next measurement is nominal.
- Back-to-back:
  - Stimulus: i_Start one cycle after o_Busy falls, with i_Window = 10 and then 200.
  - Required: counts of about 3 and about 71, each freshly cleared and not accumulated.

Source files
------------

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter.
// The block gates the RO on for a programmed number of reference cycles and
// counts RO rising edges in the RO's own clock domain. It then stops the RO,
// waits for the counter to go static, and copies the count into the
// reference domain with a one-cycle valid pulse.
`timescale 1ns/1ps
module ro_freq_counter #(
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Start,
    input  logic [WIN_W-1:0] i_Window,
    input  logic             i_RO_out,
    output logic             o_RO_Enable,
    output logic             o_RO_Sel,
    output logic [CNT_W-1:0] o_Count,
    output logic             o_Valid,
    output logic             o_Busy,
    output logic             o_Overflow
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_COUNT   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    // Reference-domain state
    state_t             state_q,   state_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
    logic               busy_q,    busy_d;
    logic               en_q,      en_d;
    logic               sel_q,     sel_d;
    logic               clear_q,   clear_d;
    logic               valid_q,   valid_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    logic               ovf_q,     ovf_d;

    // RO-domain state
    logic               sync1_q,   sync1_d;
    logic               sync2_q,   sync2_d;
    logic [CNT_W-1:0]   ro_cnt_q,  ro_cnt_d;
    logic               ro_ovf_q,  ro_ovf_d;
    logic [1:0]         ro_inc_s;
    logic [CNT_W:0]     ro_sum_s;
    logic               ro_clr_n_s;

    // Next-state and registered-output logic for the measurement sequencer
    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        set_cnt_d = set_cnt_q;
        busy_d    = busy_q;
        en_d      = 1'b0;
        sel_d     = 1'b0;
        clear_d   = 1'b0;
        valid_d   = 1'b0;
        count_d   = count_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    state_d   = ST_CLEAR;
                    win_cnt_d = i_Window;
                    busy_d    = 1'b1;
                    clear_d   = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                // A zero window goes straight to SETTLE so the RO never runs.
                if (win_cnt_q != {WIN_W{1'b0}}) begin
                    state_d   = ST_COUNT;
                    en_d      = 1'b1;
                    sel_d     = 1'b1;
                    win_cnt_d = win_cnt_q - {{(WIN_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d   = ST_SETTLE;
                    set_cnt_d = SET_LOAD;
                end
            end
            ST_COUNT: begin
                if (win_cnt_q == {WIN_W{1'b0}}) begin
                    state_d   = ST_SETTLE;
                    set_cnt_d = SET_LOAD;
                end else begin
                    en_d      = 1'b1;
                    sel_d     = 1'b1;
                    win_cnt_d = win_cnt_q - {{(WIN_W-1){1'b0}}, 1'b1};
                end
            end
            ST_SETTLE: begin
                if (set_cnt_q == {SET_W{1'b0}}) begin
                    state_d   = ST_CAPTURE;
                end else begin
                    set_cnt_d = set_cnt_q - {{(SET_W-1){1'b0}}, 1'b1};
                end
            end
            ST_CAPTURE: begin
                // The RO has been stopped for SETTLE_CYC cycles, so the
                // RO-domain count is static and safe to sample directly.
                state_d = ST_IDLE;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                count_d = ro_cnt_q;
                ovf_d   = ro_ovf_q;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Reference-domain registers; reset clears every output at once
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= ST_IDLE;
            win_cnt_q <= {WIN_W{1'b0}};
            set_cnt_q <= {SET_W{1'b0}};
            busy_q    <= 1'b0;
            en_q      <= 1'b0;
            sel_q     <= 1'b0;
            clear_q   <= 1'b0;
            valid_q   <= 1'b0;
            count_q   <= {CNT_W{1'b0}};
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            set_cnt_q <= set_cnt_d;
            busy_q    <= busy_d;
            en_q      <= en_d;
            sel_q     <= sel_d;
            clear_q   <= clear_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    // The RO-domain clear comes from a flop, so this async reset is glitch-free.
    assign ro_clr_n_s = i_Rst_n & ~clear_q;

    // RO-domain enable synchroniser and saturating edge counter.
    // The RO only toggles while enabled, so the two edges that fill the
    // synchroniser are real window edges; they are added in one step when the
    // synchronised enable first goes high.
    always_comb begin
        sync1_d  = en_q;
        sync2_d  = sync1_q;
        ro_cnt_d = ro_cnt_q;
        ro_ovf_d = ro_ovf_q;
        if (sync2_q) begin
            ro_inc_s = 2'd1;
        end else if (sync1_q) begin
            ro_inc_s = 2'd2;
        end else begin
            ro_inc_s = 2'd0;
        end
        ro_sum_s = {1'b0, ro_cnt_q} + {{(CNT_W-1){1'b0}}, ro_inc_s};
        if (ro_sum_s >= {1'b0, CNT_MAX}) begin
            ro_cnt_d = CNT_MAX;
            ro_ovf_d = 1'b1;
        end else begin
            ro_cnt_d = ro_sum_s[CNT_W-1:0];
        end
    end

    // RO-domain registers, clocked by the oscillator itself
    always_ff @(posedge i_RO_out or negedge ro_clr_n_s) begin
        if (!ro_clr_n_s) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            ro_cnt_q <= {CNT_W{1'b0}};
            ro_ovf_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            ro_cnt_q <= ro_cnt_d;
            ro_ovf_q <= ro_ovf_d;
        end
    end

    assign o_RO_Enable = en_q;
    assign o_RO_Sel    = sel_q;
    assign o_Count     = count_q;
    assign o_Valid     = valid_q;
    assign o_Busy      = busy_q;
    assign o_Overflow  = ovf_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Scoreboard bench for ro_freq_counter: two instances (16-bit counter with a
// 27.94 ns RO, 4-bit counter with a 5 ns RO). Stimulus pushes expected
// results; per-instance monitors pop and compare on every o_Valid.
`timescale 1ns/1ps
module tb_ro_freq_counter;

    localparam int  SET = 4;
    localparam real HALF_A = 13.97;
    localparam real HALF_B = 2.5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_start = 1'b0;
    logic [15:0] a_win = 16'd0;
    logic        a_ro = 1'b1;
    logic        a_en, a_sel, a_valid, a_busy, a_ovf;
    logic [15:0] a_cnt;

    logic        b_start = 1'b0;
    logic [15:0] b_win = 16'd0;
    logic        b_ro = 1'b1;
    logic        b_en, b_sel, b_valid, b_busy, b_ovf;
    logic [3:0]  b_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int en_cyc_a = 0;

    typedef struct {
        int   lo;
        int   hi;
        logic ovf;
        int   t0;
        int   lat;
        int   en_base;
        int   en_exp;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    ro_freq_counter #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(SET)) u_dut_a (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(a_start), .i_Window(a_win),
        .i_RO_out(a_ro), .o_RO_Enable(a_en), .o_RO_Sel(a_sel),
        .o_Count(a_cnt), .o_Valid(a_valid), .o_Busy(a_busy), .o_Overflow(a_ovf)
    );

    ro_freq_counter #(.CNT_W(4), .WIN_W(16), .SETTLE_CYC(SET)) u_dut_b (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(b_start), .i_Window(b_win),
        .i_RO_out(b_ro), .o_RO_Enable(b_en), .o_RO_Sel(b_sel),
        .o_Count(b_cnt), .o_Valid(b_valid), .o_Busy(b_busy), .o_Overflow(b_ovf)
    );

    // 10 ns reference clock
    always #5 clk = ~clk;

    // Reference edge counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Count cycles with the RO enabled (sampled mid-cycle)
    always @(negedge clk) if (a_en) en_cyc_a <= en_cyc_a + 1;

    // RO model A: rests high, toggles every HALF_A while enabled
    always begin
        @(posedge a_en);
        while (a_en) begin
            #(HALF_A);
            a_ro = a_en ? ~a_ro : 1'b1;
        end
    end

    // RO model B: same, faster
    always begin
        @(posedge b_en);
        while (b_en) begin
            #(HALF_B);
            b_ro = b_en ? ~b_ro : 1'b1;
        end
    end

    task automatic check(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor A: compare every presented result against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (a_valid) begin
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_valid: got o_Valid=1 with count %0d required no valid", a_cnt);
            end else begin
                e = qa.pop_front();
                check("a_count", int'(a_cnt), e.lo, e.hi);
                check("a_overflow", int'(a_ovf), int'(e.ovf), int'(e.ovf));
                check("a_latency", cyc - e.t0, e.lat, e.lat);
                check("a_enable_cycles", en_cyc_a - e.en_base, e.en_exp, e.en_exp);
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        exp_t e;
        if (b_valid) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected_valid: got o_Valid=1 with count %0d required no valid", b_cnt);
            end else begin
                e = qb.pop_front();
                check("b_count", int'(b_cnt), e.lo, e.hi);
                check("b_overflow", int'(b_ovf), int'(e.ovf), int'(e.ovf));
                check("b_latency", cyc - e.t0, e.lat, e.lat);
            end
        end
    end

    task automatic pulse_a(input int w);
        @(posedge clk); #1;
        a_win   = 16'(w);
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
    endtask

    task automatic start_a(input int w, input int lo, input int hi, input logic ovf);
        exp_t e;
        @(posedge clk); #1;
        a_win     = 16'(w);
        a_start   = 1'b1;
        e.lo      = lo;
        e.hi      = hi;
        e.ovf     = ovf;
        e.t0      = cyc + 1;
        e.lat     = 1 + w + SET + 1;
        e.en_base = en_cyc_a;
        e.en_exp  = w;
        qa.push_back(e);
        @(posedge clk); #1;
        a_start = 1'b0;
    endtask

    task automatic start_b(input int w, input int lo, input int hi, input logic ovf);
        exp_t e;
        @(posedge clk); #1;
        b_win     = 16'(w);
        b_start   = 1'b1;
        e.lo      = lo;
        e.hi      = hi;
        e.ovf     = ovf;
        e.t0      = cyc + 1;
        e.lat     = 1 + w + SET + 1;
        e.en_base = 0;
        e.en_exp  = 0;
        qb.push_back(e);
        @(posedge clk); #1;
        b_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (qa.size() == 0 && qb.size() == 0 && !a_busy && !b_busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got pending=%0d required 0", name, qa.size() + qb.size());
            qa.delete();
            qb.delete();
        end
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_enable", int'(a_en), 0, 0);
        check("rst_sel", int'(a_sel | b_sel), 0, 0);
        check("rst_busy", int'(a_busy | b_busy), 0, 0);
        check("rst_valid", int'(a_valid | b_valid), 0, 0);
        check("rst_count", int'(a_cnt) + int'(b_cnt), 0, 0);
        check("rst_overflow", int'(a_ovf | b_ovf), 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Nominal: 1000 ns window, 27.94 ns RO -> 35 or 36 edges
        start_a(100, 35, 36, 1'b0);
        wait_done("nominal");

        // Zero window: RO never enabled, valid after 6 cycles, count 0
        start_a(0, 0, 0, 1'b0);
        wait_done("zero_window");

        // Start while busy: second start (with a different window) is dropped
        start_a(100, 35, 36, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        a_win   = 16'd7;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_win   = 16'd100;
        wait_done("start_busy");

        // Saturation on the 4-bit instance, then overflow clears
        start_b(20, 15, 15, 1'b1);
        wait_done("saturate");
        start_b(2, 3, 4, 1'b0);
        wait_done("saturate_clear");

        // Reset in the middle of COUNT: outputs drop with no clock edge
        pulse_a(100);
        repeat (50) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_enable", int'(a_en), 0, 0);
        check("midrst_busy", int'(a_busy), 0, 0);
        check("midrst_count", int'(a_cnt), 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (150) @(posedge clk);
        check("midrst_idle_busy", int'(a_busy), 0, 0);
        start_a(100, 35, 36, 1'b0);
        wait_done("after_reset");

        // Back-to-back: each measurement freshly cleared
        start_a(10, 3, 4, 1'b0);
        wait_done("b2b_short");
        start_a(200, 71, 72, 1'b0);
        wait_done("b2b_long");

        repeat (5) @(posedge clk);
        check("queue_a_empty", qa.size(), 0, 0);
        check("queue_b_empty", qb.size(), 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
